// File: rtl/gol_pkg.sv
// Shared types and helpers for the life-grid LED matrix scanner.
// Grid geometry, scanner state encoding and the cell index helper.
package gol_pkg;

   localparam int GRID_W   = 64;
   localparam int GRID_DIM = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH,
      HOLD
   } scan_state_t;

   // Cell (row, col) lives at row*8+col; cell 0 is top-left.
   function automatic logic [5:0] cell_index(
      input logic [2:0] row,
      input logic [2:0] col
   );
      return 6'(row) * 6'(GRID_DIM) + 6'(col);
   endfunction

endpackage

// File: rtl/gol_clk_div.sv
// Phase counter: counts TERM cycles per phase while run is high.
// Ports: clk, rst_n (async low), clear, run -> level (toggles per phase), strobe (last cycle of phase).
module gol_clk_div #(
   parameter int TERM = 4,
   parameter int W    = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic level,
   output logic strobe
);

   localparam logic [W-1:0] LAST = W'(TERM - 1);

   logic [W-1:0] cnt;

   // Strobe marks the final cycle of a phase; the counter never
   // runs past LAST, it returns to zero on the strobe.
   assign strobe = run && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (run) begin
         if (strobe) begin
            cnt   <= '0;
            level <= ~level;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/grid_matrix_scanner.sv
// Snapshots the 64-cell life grid per frame and scans it onto an 8x8 LED matrix.
// Ports: clka, rst_n, grid[63:0], enable -> ser_data, ser_clk, ser_latch, row_sel[7:0], frame_done, busy.
module grid_matrix_scanner
   import gol_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int ROW_HOLD = 1000
)(
   input  logic              clka,
   input  logic              rst_n,
   input  logic [GRID_W-1:0] grid,
   input  logic              enable,
   output logic              ser_data,
   output logic              ser_clk,
   output logic              ser_latch,
   output logic [7:0]        row_sel,
   output logic              frame_done,
   output logic              busy
);

   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HOLD_W = $clog2(ROW_HOLD + 1);

   scan_state_t       state;
   logic [GRID_W-1:0] frame_buf;
   logic [2:0]        row;
   logic [2:0]        bitc;

   logic div_stb;
   logic hold_stb;
   logic hold_lvl_unused;
   logic in_load;
   logic in_shift;
   logic in_hold;
   logic bit_end;

   assign in_load  = (state == LOAD);
   assign in_shift = (state == SHIFT);
   assign in_hold  = (state == HOLD);

   // ser_clk is the divider's registered phase level; it is low on
   // entry to SHIFT and returns low after the high phase of bit 0.
   gol_clk_div #(
      .TERM (CLK_DIV),
      .W    (DIV_W)
   ) u_div (
      .clk    (clka),
      .rst_n  (rst_n),
      .clear  (in_load),
      .run    (in_shift),
      .level  (ser_clk),
      .strobe (div_stb)
   );

   gol_clk_div #(
      .TERM (ROW_HOLD),
      .W    (HOLD_W)
   ) u_hold (
      .clk    (clka),
      .rst_n  (rst_n),
      .clear  (in_load),
      .run    (in_hold),
      .level  (hold_lvl_unused),
      .strobe (hold_stb)
   );

   // A bit ends at the last cycle of its high phase.
   assign bit_end = div_stb && ser_clk;

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_buf  <= '0;
         row        <= '0;
         bitc       <= '0;
         ser_data   <= 1'b0;
         ser_latch  <= 1'b0;
         row_sel    <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         ser_latch  <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               ser_data <= 1'b0;
               row_sel  <= '0;
               if (enable) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               frame_buf <= grid;
               row       <= '0;
               bitc      <= 3'd7;
               row_sel   <= '0;
               // First bit comes straight from grid since
               // frame_buf only settles on this same edge.
               ser_data  <= grid[cell_index(3'd0, 3'd7)];
               state     <= SHIFT;
            end
            SHIFT: begin
               if (bit_end) begin
                  if (bitc == 3'd0) begin
                     ser_latch <= 1'b1;
                     ser_data  <= 1'b0;
                     state     <= LATCH;
                  end else begin
                     bitc     <= bitc - 3'd1;
                     ser_data <= frame_buf[
                        cell_index(row, bitc - 3'd1)];
                  end
               end
            end
            LATCH: begin
               row_sel <= 8'd1 << row;
               state   <= HOLD;
            end
            HOLD: begin
               if (hold_stb) begin
                  row_sel <= '0;
                  if (row != 3'd7) begin
                     row      <= row + 3'd1;
                     bitc     <= 3'd7;
                     ser_data <= frame_buf[
                        cell_index(row + 3'd1, 3'd7)];
                     state    <= SHIFT;
                  end else begin
                     frame_done <= 1'b1;
                     if (enable) begin
                        state <= LOAD;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
